// File: rtl/conv_channel_accumulator_pkg.sv
// Shared sizing for the channel accumulator: default geometry, counter widths
// and saturation limits at the default data width.
package conv_channel_accumulator_pkg;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DATA_WIDTH       = 32;
  localparam int IMAGE_WIDTH      = 16;
  localparam int IMAGE_HEIGHT     = 16;
  localparam int IMAGE_SIZE       = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CHANNEL_NUM_IN   = 3;
  localparam int CHANNEL_NUM_OUT  = 8;
  localparam int CNT_PXL_WIDTH    = cnt_width(IMAGE_SIZE);
  localparam int CNT_CH_IN_WIDTH  = cnt_width(CHANNEL_NUM_IN);
  localparam int CNT_CH_OUT_WIDTH = cnt_width(CHANNEL_NUM_OUT);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/conv_acc_sat_adder.sv
// Combinational signed add with clamp to the DATA_WIDTH two's-complement range.
module conv_acc_sat_adder #(
  parameter int DATA_WIDTH = conv_channel_accumulator_pkg::DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_sum
);
  import conv_channel_accumulator_pkg::*;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Overflow shows up as disagreement between the two top bits of the wide sum.
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] v);
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
      return v[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    return v[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH:0] w_wide;

  assign w_wide = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};
  assign o_sum  = sat(w_wide);

endmodule

// File: rtl/conv_channel_accumulator.sv
// Sums CHANNEL_NUM_IN consecutive partial-sum planes pixel-wise and emits one
// saturated, optionally ReLU'd plane per output channel, one cycle after the final channel.
module conv_channel_accumulator #(
  parameter int DATA_WIDTH       = conv_channel_accumulator_pkg::DATA_WIDTH,
  parameter int IMAGE_WIDTH      = conv_channel_accumulator_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT     = conv_channel_accumulator_pkg::IMAGE_HEIGHT,
  parameter int IMAGE_SIZE       = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN   = conv_channel_accumulator_pkg::CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT  = conv_channel_accumulator_pkg::CHANNEL_NUM_OUT,
  parameter int CNT_PXL_WIDTH    = conv_channel_accumulator_pkg::cnt_width(IMAGE_SIZE),
  parameter int CNT_CH_IN_WIDTH  = conv_channel_accumulator_pkg::cnt_width(CHANNEL_NUM_IN),
  parameter int CNT_CH_OUT_WIDTH = conv_channel_accumulator_pkg::cnt_width(CHANNEL_NUM_OUT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  input  logic                        relu_en,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                        valid_out,
  output logic [CNT_CH_OUT_WIDTH-1:0] ch_out_idx,
  output logic                        plane_done,
  output logic                        layer_done
);
  import conv_channel_accumulator_pkg::*;

  localparam logic [CNT_PXL_WIDTH-1:0]    PXL_LAST    = CNT_PXL_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CNT_CH_IN_WIDTH-1:0]  CH_IN_LAST  = CNT_CH_IN_WIDTH'(CHANNEL_NUM_IN - 1);
  localparam logic [CNT_CH_OUT_WIDTH-1:0] CH_OUT_LAST = CNT_CH_OUT_WIDTH'(CHANNEL_NUM_OUT - 1);

  // Same-address read-modify-writes are IMAGE_SIZE accepts apart, so the RAM needs no forwarding.
  if (IMAGE_SIZE < 2) begin : g_size_check
    $error("conv_channel_accumulator: IMAGE_SIZE must be at least 2");
  end

  function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] v,
                                                        input logic en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  logic [CNT_PXL_WIDTH-1:0]    r_pxl_cnt;
  logic [CNT_CH_IN_WIDTH-1:0]  r_ch_in_cnt;
  logic [CNT_CH_OUT_WIDTH-1:0] r_ch_out_cnt;
  logic signed [DATA_WIDTH-1:0] r_acc [IMAGE_SIZE];

  logic                         w_last_pxl;
  logic                         w_last_ch_in;
  logic                         w_last_ch_out;
  logic                         w_emit;
  logic signed [DATA_WIDTH-1:0] w_base;
  logic signed [DATA_WIDTH-1:0] w_sum;

  logic signed [DATA_WIDTH-1:0] r_pxl_out_p1;
  logic                         r_vld_p1;
  logic [CNT_CH_OUT_WIDTH-1:0]  r_ch_out_idx_p1;
  logic                         r_plane_done_p1;
  logic                         r_layer_done_p1;

  assign w_last_pxl    = (r_pxl_cnt == PXL_LAST);
  assign w_last_ch_in  = (r_ch_in_cnt == CH_IN_LAST);
  assign w_last_ch_out = (r_ch_out_cnt == CH_OUT_LAST);
  assign w_emit        = valid_in && w_last_ch_in;

  // Channel 0 starts from zero, so stale RAM contents never leak into a new plane.
  assign w_base = (r_ch_in_cnt == '0) ? '0 : r_acc[r_pxl_cnt];

  conv_acc_sat_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_adder (
    .i_a  (w_base),
    .i_b  (pxl_in),
    .o_sum(w_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pxl_cnt    <= '0;
      r_ch_in_cnt  <= '0;
      r_ch_out_cnt <= '0;
    end else if (valid_in) begin
      if (w_last_pxl) begin
        r_pxl_cnt <= '0;
        if (w_last_ch_in) begin
          r_ch_in_cnt  <= '0;
          r_ch_out_cnt <= w_last_ch_out ? '0 : r_ch_out_cnt + 1'b1;
        end else begin
          r_ch_in_cnt <= r_ch_in_cnt + 1'b1;
        end
      end else begin
        r_pxl_cnt <= r_pxl_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in)
      r_acc[r_pxl_cnt] <= w_sum;
  end

  // p0 -> p1: accept-cycle sum registered as the output pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pxl_out_p1    <= '0;
      r_vld_p1        <= 1'b0;
      r_ch_out_idx_p1 <= '0;
      r_plane_done_p1 <= 1'b0;
      r_layer_done_p1 <= 1'b0;
    end else begin
      r_vld_p1        <= w_emit;
      r_plane_done_p1 <= w_emit && w_last_pxl;
      r_layer_done_p1 <= w_emit && w_last_pxl && w_last_ch_out;
      if (w_emit) begin
        r_pxl_out_p1    <= relu(w_sum, relu_en);
        r_ch_out_idx_p1 <= r_ch_out_cnt;
      end
    end
  end

  assign pxl_out    = r_pxl_out_p1;
  assign valid_out  = r_vld_p1;
  assign ch_out_idx = r_ch_out_idx_p1;
  assign plane_done = r_plane_done_p1;
  assign layer_done = r_layer_done_p1;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Bench for conv_channel_accumulator: directed vector tables, corner sequences
// and randomized traffic against a plain-arithmetic plane-sum model.
module tb_conv_channel_accumulator;
  localparam int DW   = 16;
  localparam int IS   = 4;
  localparam int CIN  = 3;
  localparam int COUT = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 valid_in;
  logic signed [DW-1:0] pxl_in;
  logic                 relu_en;
  logic signed [DW-1:0] pxl_out;
  logic                 valid_out;
  logic [0:0]           ch_out_idx;
  logic                 plane_done;
  logic                 layer_done;

  conv_channel_accumulator #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .relu_en(relu_en),
    .pxl_out(pxl_out), .valid_out(valid_out), .ch_out_idx(ch_out_idx),
    .plane_done(plane_done), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted-pixel count gives pixel / channel / output channel.
  int acc [IS];
  int n_acc = 0;
  int m_vld = 0, m_pxl = 0, m_idx = 0, m_pd = 0, m_ld = 0;

  typedef struct {
    bit v; int pxl; bit relu;
    bit ev; int epxl; int eidx; bit epd; bit eld;
  } vec_t;
  vec_t tbl [24];

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input int p, input bit r);
    int px, ch, och, s;
    reset = rst; valid_in = v; pxl_in = 16'(p); relu_en = r;
    if (rst) begin
      n_acc = 0; m_vld = 0; m_pxl = 0; m_idx = 0; m_pd = 0; m_ld = 0;
    end else begin
      m_vld = 0; m_pd = 0; m_ld = 0;
      if (v) begin
        px  = n_acc % IS;
        ch  = (n_acc / IS) % CIN;
        och = n_acc / (IS * CIN);
        s   = clamp(((ch == 0) ? 0 : acc[px]) + p);
        acc[px] = s;
        if (ch == CIN - 1) begin
          m_vld = 1;
          m_pxl = (r && s < 0) ? 0 : s;
          m_idx = och;
          m_pd  = (px == IS - 1);
          m_ld  = m_pd && (och == COUT - 1);
        end
        n_acc = (n_acc + 1) % (IS * CIN * COUT);
      end
    end
    @(posedge clk);
    #1;
    chk("valid_out", int'(valid_out), m_vld);
    chk("pxl_out", int'(pxl_out), m_pxl);
    chk("ch_out_idx", int'(ch_out_idx), m_idx);
    chk("plane_done", int'(plane_done), m_pd);
    chk("layer_done", int'(layer_done), m_ld);
  endtask

  task automatic first_stream(input bit gaps, input string tag);
    for (int c = 0; c < CIN; c++) begin
      for (int i = 0; i < IS; i++) begin
        int mult;
        mult = (c == 0) ? 1 : ((c == 1) ? 10 : 100);
        step(1'b0, 1'b1, mult * (i + 1), 1'b0);
        if (c == CIN - 1) begin
          chk({tag, "_pxl"}, int'(pxl_out), 111 * (i + 1));
          chk({tag, "_idx"}, int'(ch_out_idx), 0);
        end
        if (gaps) begin
          int g;
          g = int'($urandom_range(1, 5));
          for (int k = 0; k < g; k++) step(1'b0, 1'b0, 0, 1'b0);
        end
      end
    end
  endtask

  initial begin
    // Plane 0: ch0 {1..4}, ch1 {10..40}, ch2 {100..400}; plane 1: -5 everywhere.
    for (int c = 0; c < CIN; c++) begin
      for (int i = 0; i < IS; i++) begin
        int mult;
        mult = (c == 0) ? 1 : ((c == 1) ? 10 : 100);
        tbl[c*IS + i]      = '{1'b1, mult * (i + 1), 1'b0,
                               c == 2, 111 * (i + 1), 0, (c == 2) && (i == 3), 1'b0};
        tbl[12 + c*IS + i] = '{1'b1, -5, 1'b0,
                               c == 2, -15, 1, (c == 2) && (i == 3), (c == 2) && (i == 3)};
      end
    end

    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      step(1'b0, tbl[k].v, tbl[k].pxl, tbl[k].relu);
      chk("tbl_valid", int'(valid_out), int'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk("tbl_pxl", int'(pxl_out), tbl[k].epxl);
        chk("tbl_idx", int'(ch_out_idx), tbl[k].eidx);
      end
      chk("tbl_plane_done", int'(plane_done), int'(tbl[k].epd));
      chk("tbl_layer_done", int'(layer_done), int'(tbl[k].eld));
    end

    // Wrapped to layer 0: -5 planes with ReLU give zeros on output channel 0.
    for (int k = 0; k < CIN * IS; k++) begin
      step(1'b0, 1'b1, -5, 1'b1);
      if (k >= (CIN - 1) * IS) begin
        chk("relu_valid", int'(valid_out), 1);
        chk("relu_zero", int'(pxl_out), 0);
      end
    end

    // Saturation at every channel step, on output channel 1.
    begin
      int sat_in [IS][CIN];
      int sat_exp [IS];
      sat_in[0] = '{30000, 30000, 30000};    sat_exp[0] = 32767;
      sat_in[1] = '{-30000, -30000, -30000}; sat_exp[1] = -32768;
      sat_in[2] = '{30000, 30000, -30000};   sat_exp[2] = 2767;
      sat_in[3] = '{-30000, -30000, 30000};  sat_exp[3] = -2768;
      for (int c = 0; c < CIN; c++)
        for (int i = 0; i < IS; i++) begin
          step(1'b0, 1'b1, sat_in[i][c], 1'b0);
          if (c == CIN - 1) chk("sat_pxl", int'(pxl_out), sat_exp[i]);
        end
    end

    first_stream(1'b1, "gaps");

    // Reset after two ch1 pixels discards the partial sums.
    for (int i = 0; i < IS; i++) step(1'b0, 1'b1, 7000, 1'b0);
    step(1'b0, 1'b1, 7000, 1'b0);
    step(1'b0, 1'b1, 7000, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    first_stream(1'b0, "replay");

    // Reset in the cycle after a final-channel accept clears the pending output.
    for (int i = 0; i < 2 * IS + 1; i++) step(1'b0, 1'b1, i - 4, 1'b0);
    chk("pre_reset_valid", int'(valid_out), 1);
    step(1'b1, 1'b1, 123, 1'b0);
    chk("reset_clears_valid", int'(valid_out), 0);

    for (int k = 0; k < 600; k++) begin
      bit v, r, rst;
      int p;
      rst = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) < 7);
      r   = $urandom_range(0, 1) == 1;
      p   = int'($urandom_range(0, 40000)) - 20000;
      step(rst, v, p, r);
    end

    step(1'b0, 1'b0, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_channel_accumulator.md
Name: conv_channel_accumulator

Overview:
- Receiving end of the per-channel convolution output stream.
- The 3x3 conv engine emits one partial-sum plane per input channel: IMAGE_SIZE pixels, raster order, channel-major.
- This block accumulates CHANNEL_NUM_IN consecutive planes element-wise and emits one summed output plane per output channel, with optional ReLU and saturation.
- It sits directly after the conv core, in the slot reserved for the channel adder.

Parameters:
- DATA_WIDTH, 32, signed two's-complement pixel / partial-sum width.
- IMAGE_WIDTH, 16, output plane width in pixels.
- IMAGE_HEIGHT, 16, output plane height in pixels.
- IMAGE_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT, pixels per plane and accumulator depth.
- CHANNEL_NUM_IN, 3, planes summed per output plane.
- CHANNEL_NUM_OUT, 8, output planes per layer.
- CNT_PXL_WIDTH, clog2(IMAGE_SIZE), pixel counter width.
- CNT_CH_IN_WIDTH, clog2(CHANNEL_NUM_IN) (min 1), input-channel counter width.
- CNT_CH_OUT_WIDTH, clog2(CHANNEL_NUM_OUT) (min 1), output-channel counter width.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- valid_in, input, 1, pxl_in carries one partial-sum pixel this cycle.
- pxl_in, input, DATA_WIDTH, signed partial sum from the conv core.
- relu_en, input, 1, clamp negative results to 0; sampled with each final-channel pixel.
- pxl_out, output, DATA_WIDTH, summed (saturated, optionally ReLU'd) pixel.
- valid_out, output, 1, pxl_out valid this cycle.
- ch_out_idx, output, CNT_CH_OUT_WIDTH, output channel index of the current pxl_out.
- plane_done, output, 1, one-cycle pulse coincident with the last pixel of an output plane.
- layer_done, output, 1, one-cycle pulse coincident with the last pixel of output channel CHANNEL_NUM_OUT-1.

Behaviour:
- Reset (synchronous, active-high):
  - pxl_cnt, ch_in_cnt and ch_out_cnt go to 0.
  - pxl_out, valid_out, ch_out_idx, plane_done and layer_done go to 0.
  - Accumulator RAM contents are not cleared; they are don't-care because channel 0 overwrites them.
- Counters advance only on valid_in=1. Gaps of any length are legal and do not change state.
- Counter sequence per accepted pixel:
  - pxl_cnt increments, wrapping at IMAGE_SIZE-1.
  - On pxl_cnt wrap, ch_in_cnt increments, wrapping at CHANNEL_NUM_IN-1.
  - On ch_in_cnt wrap, ch_out_cnt increments, wrapping at CHANNEL_NUM_OUT-1 back to 0. The next layer begins with no idle cycle required.
- Datapath for each accepted pixel, all within the accept cycle:
  - base = 0 if ch_in_cnt==0, else acc[pxl_cnt] (combinational read).
  - sum = sat(base + pxl_in). Compute at DATA_WIDTH+1 bits, then clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - acc[pxl_cnt] <= sum.
  - Saturation applies at every channel step, not only the last.
- Output, when ch_in_cnt==CHANNEL_NUM_IN-1:
  - Next cycle: valid_out=1, pxl_out = (relu_en && sum<0) ? 0 : sum, ch_out_idx = ch_out_cnt.
  - Latency is exactly 1 cycle from the final-channel valid_in to valid_out.
  - No output is produced for channels 0..CHANNEL_NUM_IN-2.
- Read-modify-write: same-address accesses are IMAGE_SIZE accepts apart, so no forwarding is needed. IMAGE_SIZE>=2 is required; an elaboration check flags violations.
- CHANNEL_NUM_IN==1: every input passes through sat/ReLU with 1-cycle latency; the RAM is unused.
- plane_done is asserted with valid_out for the pixel at pxl_cnt==IMAGE_SIZE-1 in the final input channel. layer_done is additionally gated by ch_out_cnt==CHANNEL_NUM_OUT-1.
- Reset asserted mid-plane:
  - Any partial accumulation is discarded.
  - The next valid_in is treated as pixel 0, channel 0, output channel 0.
  - A valid_out registered before reset is cleared in the reset cycle.
- No backpressure: the downstream consumer must accept valid_out every cycle it is asserted.

Decomposition:
- Shared package/include: DATA_WIDTH, IMAGE_WIDTH, IMAGE_HEIGHT, IMAGE_SIZE, CHANNEL_NUM_IN, CHANNEL_NUM_OUT, counter widths (clog2-derived), SAT_MAX and SAT_MIN constants.
- Counters and output registers stay in the top module; the RAM is an inferred distributed array with async read and sync write.
- One sub-module: conv_acc_sat_adder. It is combinational: DATA_WIDTH-bit signed add with saturation, reused by any later bias-add stage.

Test Plan (bench uses DATA_WIDTH=16, IMAGE_WIDTH=IMAGE_HEIGHT=2 so IMAGE_SIZE=4, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2):
- Continuous stream, ch0 = {1,2,3,4}, ch1 = {10,20,30,40}, ch2 = {100,200,300,400} -> valid_out exactly 1 cycle after each ch2 pixel; pxl_out = 111, 222, 333, 444; ch_out_idx = 0; plane_done on 444.
- Second output plane, all channels = -5 for every pixel, relu_en=0 -> four outputs of -15, ch_out_idx=1; layer_done on the 4th output; the next pixel is treated as layer 0 channel 0.
- Same as above with relu_en=1 -> four outputs of 0, valid_out still asserted.
- Saturation: pixel 0 receives 30000, 30000, 30000 -> pxl_out = 32767; pixel 1 receives -30000 x3 -> -32768.
- Random valid_in gaps (1-5 idle cycles) on the first stream -> identical outputs and order; no valid_out during gaps not preceded by a ch2 accept.
- reset asserted after 2 pixels of ch1, then the first stream is replayed -> outputs 111, 222, 333, 444 with no stale contribution.
